// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch unit.
//   INSTR_W / ADDR_W   : instruction and address widths
//   fetch_entry_t      : one queued fetch {instr, pc, pred}
//   is_uncond_branch() : true for an always-condition (0xE) B/BL encoding
//   branch_target()    : PC + 8 + (sign_extend(imm24) << 2), modulo 2^32
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               pred;
    } fetch_entry_t;

    function automatic logic is_uncond_branch(input logic [INSTR_W-1:0] instr);
        return (instr[31:28] == 4'hE) && (instr[27:25] == 3'b101);
    endfunction

    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0]  pc,
                                                        input logic [INSTR_W-1:0] instr);
        // The pipeline view of PC is two words ahead, hence the +8.
        return pc + 32'd8 + {{6{instr[23]}}, instr[23:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small circular FIFO of fetch entries.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   flush      : synchronous clear; wins over push and pop
//   push       : write push_data at the tail (taken when not full, or when
//                a pop frees the slot in the same cycle)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, straight from storage
//   count      : number of valid entries
//   full/empty : occupancy flags
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // When full, the tail slot is the head slot; a simultaneous pop makes
    // overwriting it safe because the old head leaves at this same edge.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, fetch queue control and next-PC selection.
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : byte address to the combinational instruction memory (= PC)
//   imem_rdata      : word returned for imem_addr in the same cycle
//   redirect_valid  : restart fetch at redirect_pc, flushing queued words
//   redirect_pc     : new PC; low two bits are forced to zero
//   out_valid/out_instr/out_pc/out_pred : queue head towards decode
//   out_ready       : decode accepts the head
// Build option: define FETCH_BTFN_EN to enable static prediction of
// unconditional branches at enqueue; otherwise next PC is always PC+4 and
// out_pred stays 0.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               out_pred,
    input  logic               out_ready
);

    logic [ADDR_W-1:0]          pc;
    logic [ADDR_W-1:0]          next_pc;
    logic                       pred_taken;
    logic                       deq;
    logic                       enq;
    fetch_entry_t               push_data;
    fetch_entry_t               head;
    logic                       q_full;
    logic                       q_empty;
    // Occupancy is already summarised by full/empty at this level.
    logic [$clog2(QDEPTH+1)-1:0] q_count_unused;

    // Decode handshake: the head transfers on every rising edge where
    // out_valid and out_ready are both high. out_valid never depends on
    // out_ready, and a head offered with out_valid stays put until it
    // transfers or a redirect flushes it. A transfer in the redirect cycle
    // itself still counts as delivered.
    assign deq = out_valid & out_ready;
    assign enq = ~redirect_valid & (~q_full | deq);

    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc + 32'd4;
`ifdef FETCH_BTFN_EN
        if (is_uncond_branch(imem_rdata)) begin
            pred_taken = 1'b1;
            next_pc    = branch_target(pc, imem_rdata);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (enq) begin
            pc <= next_pc;
        end
    end

    assign push_data = '{instr: imem_rdata, pc: pc, pred: pred_taken};

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (push_data),
        .pop       (deq),
        .head      (head),
        .count     (q_count_unused),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign imem_addr = pc;
    assign out_valid = ~q_empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    // Without prediction every entry is pushed with pred=0, so this is
    // constant 0 in that build.
    assign out_pred  = head.pred;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit.
// The reference is a program-order stream: starting from a restart address
// (reset or redirect) the expected sequence of {pred, instr, pc} is generated
// from the memory contents with plain arithmetic, and every accepted head
// must match the front of that stream.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
`ifdef FETCH_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred;
    logic        out_ready;

    logic [31:0] rom [256];
    assign imem_rdata = rom[imem_addr[9:2]];

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred       (out_pred),
        .out_ready      (out_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference stream ----------------
    logic [64:0] exp_q[$];      // {pred, instr, pc}, program order
    logic [31:0] gen_pc;
    bit          redir_prev;
    int          stall_prev;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return rom[a[9:2]];
    endfunction

    function automatic bit predicted(input logic [31:0] w);
        return BTFN && ((w >> 28) == 32'd14) && (((w >> 25) & 32'd7) == 32'd5);
    endfunction

    task automatic refill();
        logic [31:0] w;
        bit          t;
        int          imm;
        while (exp_q.size() < 8) begin
            w = rom_word(gen_pc);
            t = predicted(w);
            exp_q.push_back({t, w, gen_pc});
            if (t) begin
                imm = int'(w & 32'h00FF_FFFF);
                if (imm >= (1 << 23)) imm = imm - (1 << 24);
                gen_pc = gen_pc + 32'(8 + imm * 4);
            end else begin
                gen_pc = gen_pc + 32'd4;
            end
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        gen_pc = (a >> 2) << 2;
        refill();
    endtask

    // ---------------- drivers ----------------
    // Drive one cycle's inputs just after a falling edge, check outputs,
    // advance the reference, and return at the next falling edge.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        logic [64:0] h;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        check("out_valid", out_valid, !redir_prev);
        if (out_valid) begin
            h = exp_q[0];
            check("out_pc", out_pc, h[31:0]);
            check("out_instr", out_instr, h[63:32]);
            check("out_pred", out_pred, h[64]);
        end
        if (redir_prev) begin
            h = exp_q[0];
            check("addr_restart", imem_addr, h[31:0]);
        end
        if (stall_prev >= QDEPTH) begin
            h = exp_q[QDEPTH];
            check("addr_stalled", imem_addr, h[31:0]);
        end
        if (out_valid && rdy) begin
            void'(exp_q.pop_front());
            refill();
        end
        if (redir) restart(rpc);
        stall_prev = (!rdy && !redir) ? stall_prev + 1 : 0;
        redir_prev = redir;
        @(negedge clk);
    endtask

    // Assert reset between edges, check the immediate effect, release on a
    // falling edge.
    task automatic do_reset();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pred", out_pred, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        restart(RESET_PC);
        redir_prev = 1'b1;
        stall_prev = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;

        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[8'h00] = 32'hE3A0_204B;
        rom[8'h01] = 32'hE04F_000F;
        rom[8'h02] = 32'hE3A0_4055;
        rom[8'h03] = 32'hE081_1002;
        rom[8'h04] = 32'hEAFF_FFFE;   // 0x10: branch to itself when predicted
        rom[8'h05] = 32'hE1A0_0000;
        rom[8'h08] = 32'hE1A0_0001;   // 0x20
        rom[8'h09] = 32'hE1A0_0002;
        rom[8'h10] = 32'h0AFF_FFFE;   // 0x40: same branch, cond 0 -> never predicted
        rom[8'h11] = 32'hE1A0_0003;
        rom[8'hFE] = 32'hE1A0_0004;   // 0xFFFF_FFF8
        rom[8'hFF] = 32'hE281_1001;   // 0xFFFF_FFFC

        rst_n      = 1'b0;
        redir_prev = 1'b1;
        stall_prev = 0;
        @(negedge clk);
        do_reset();

        // Straight-line stream, decode always ready.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        // Back-pressure: queue fills, PC stalls.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect to an unaligned address while full and ready.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0023);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Non-predicted branch encoding, then predicted one.
        step(1'b1, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0010);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Address wrap-around.
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

        // Mid-stream asynchronous reset, then stall straight after release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                rpc = 32'($urandom_range(0, 1023));
            step(rdy, redir, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit: the initiator that drives the word address into the combinational instruction memory and consumes its read data. It holds the program counter, buffers fetched words with their PCs in a small queue, and presents them to decode over a valid/ready handshake. A redirect input lets execute restart fetch at a new PC and flush stale words.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- QDEPTH, 2, fetch queue entries (≥2, power of two)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to instruction memory (equals PC; memory uses [31:2])
- imem_rdata  in  32  instruction word, combinational from imem_addr in the same cycle
- redirect_valid  in  1  restart fetch this cycle
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  queue head valid
- out_instr  out  32  queue head instruction
- out_pc  out  32  address of out_instr
- out_pred  out  1  head was predicted taken (see Configuration)
- out_ready  in  1  decode accepts head

## Operation
- One clock; reset is asynchronous and active-low: rst_n low → PC=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, out_pred=0, immediately and independent of clk.
- imem_addr is driven directly from the PC register (no combinational path from any input).
- deq = out_valid & out_ready; enq = ~redirect_valid & (count<QDEPTH | deq).
- On enq: push {imem_rdata, PC, pred} to the queue tail; PC ← next_pc.
- next_pc = PC+4, modulo 2^32 (0xFFFF_FFFC → 0x0000_0000), unless prediction applies.
- Redirect (priority over everything): queue cleared, PC ← {redirect_pc[31:2],2'b00}, no enqueue that cycle. A deq in the same cycle counts as completed (decode consumed the head); all other entries are discarded.
- Full with deq: enqueue and dequeue in the same cycle; count unchanged.
- Empty: out_valid=0; out_instr/out_pc hold their last values (don't care).
- Outputs come from the queue head registers; order is strictly program order between redirects.

## Timing
- Fetch-to-out latency: 1 cycle. A word addressed during cycle N appears on out_* after the edge ending N.
- First valid: first rising edge after rst_n deasserts enqueues ROM[RESET_PC>>2]; out_valid=1 from then on.
- Redirect asserted in cycle N: out_valid=0 in cycle N+1; target word valid in N+2.
- Sustained throughput: 1 instruction/cycle with out_ready held high.
- out_ready low for K cycles: queue fills after QDEPTH cycles, PC stalls; no word lost or duplicated.

## Configuration
- FETCH_BTFN_EN defined: static prediction at enqueue. If imem_rdata[31:28]==4'hE and [27:25]==3'b101, next_pc = PC + 8 + (sign_extend(imm24) << 2), mod 2^32; the entry's pred=1. All other words use PC+4, pred=0.
- Undefined: next_pc always PC+4; out_pred tied 0. The port exists in both builds.

## Structure
- fetch_pkg: INSTR_W=32, ADDR_W=32, fetch entry struct {instr, pc, pred}, function is_uncond_branch(instr), function branch_target(pc, instr).
- Sub-module fetch_queue: parametric FIFO of fetch entries with push, pop, synchronous flush, count/full/empty; flush has priority over push.
- instr_fetch_unit: PC register, enq/deq control, next-PC selection.

## Test plan
- Reset, out_ready=1, memory of words 0xE3A0204B, 0xE04F000F, 0xE3A04055 at 0x0/0x4/0x8 → out_pc 0,4,8 on consecutive cycles starting the first edge after reset, correct words, no gaps.
- Hold out_ready=0 for 5 cycles, then 1 → imem_addr stops at 0x8 (QDEPTH=2); subsequent stream 0x0, 0x4, 0x8, … with no loss or duplication.
- Redirect to 0x23 while queue is full and out_ready=1 → head consumed that cycle, out_valid=0 next cycle, then out_pc=0x20.
- RESET_PC=0xFFFF_FFF8 → out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- FETCH_BTFN_EN, word 0xEAFFFFFE at 0x10 → out_pred=1 for it, next out_pc=0x10; same word with cond 0x0 (0x0AFFFFFE) → out_pred=0, next out_pc=0x14.
- Assert rst_n low mid-stream between edges → out_valid=0 and imem_addr=RESET_PC immediately; fetch restarts at RESET_PC after release.
